// File: rtl/irq_ctrl_if.sv
// Interrupt controller bus: timer interrupt lines, consumer handshake and status.
interface irq_ctrl_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2
);
  logic [N_SRC-1:0] i_irq;
  logic [N_SRC-1:0] i_mask;
  logic             i_irq_ack;
  logic             i_ovr_clr;
  logic             o_irq_req;
  logic [ID_W-1:0]  o_irq_id;
  logic [N_SRC-1:0] o_clear;
  logic [N_SRC-1:0] o_pending;
  logic [N_SRC-1:0] o_overrun;

  // Environment side: drives interrupts, mask and handshake.
  modport master (
    output i_irq, i_mask, i_irq_ack, i_ovr_clr,
    input  o_irq_req, o_irq_id, o_clear, o_pending, o_overrun
  );

  // Controller side.
  modport slave (
    input  i_irq, i_mask, i_irq_ack, i_ovr_clr,
    output o_irq_req, o_irq_id, o_clear, o_pending, o_overrun
  );
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: captures timer interrupt edges into a
// pending register, requests the lowest enabled pending source, and pulses
// the timer's clear once the consumer acknowledges.
module irq_ctrl #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  irq_ctrl_if.slave    bus
);

  // The source index must be able to address every source.
  if ((2 ** ID_W) < N_SRC) begin : g_id_check
    $error("irq_ctrl: ID_W too narrow for N_SRC");
  end

  typedef enum logic [1:0] {IDLE, REQ, CLR, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] prev;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] overrun;
  logic [N_SRC-1:0] clear_q;
  logic             req_q;
  logic [ID_W-1:0]  id_q;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ready;
  logic [N_SRC-1:0] pending_nxt;
  logic [N_SRC-1:0] overrun_nxt;
  logic [N_SRC-1:0] clear_nxt;
  logic [ID_W-1:0]  lowest;
  logic [ID_W-1:0]  id_nxt;
  logic             req_nxt;

  // Edge detect, pending capture and overrun tracking; a new edge beats a clear.
  always_comb begin
    rise        = bus.i_irq & ~prev;
    ready       = pending & bus.i_mask;
    pending_nxt = (pending & ~clear_q) | rise;
    overrun_nxt = (bus.i_ovr_clr ? '0 : overrun) | (rise & pending & ~clear_q);
  end

  // Lowest-index enabled pending source wins.
  always_comb begin
    lowest = '0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      if (ready[k]) lowest = ID_W'(k);
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    req_nxt   = 1'b0;
    clear_nxt = '0;
    case (state)
      IDLE: begin
        if (|ready) begin
          id_nxt    = lowest;
          state_nxt = REQ;
        end
      end
      REQ:     if (bus.i_irq_ack) state_nxt = CLR;
      CLR:     state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    req_nxt   = (state_nxt == REQ);
    clear_nxt = (state_nxt == CLR) ? (N_SRC'(1) << id_nxt) : '0;
  end

  // Interrupt capture registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev    <= '0;
      pending <= '0;
      overrun <= '0;
    end else begin
      prev    <= bus.i_irq;
      pending <= pending_nxt;
      overrun <= overrun_nxt;
    end
  end

  // FSM state and registered request/clear outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      id_q    <= '0;
      req_q   <= 1'b0;
      clear_q <= '0;
    end else begin
      state   <= state_nxt;
      id_q    <= id_nxt;
      req_q   <= req_nxt;
      clear_q <= clear_nxt;
    end
  end

  assign bus.o_irq_req = req_q;
  assign bus.o_irq_id  = id_q;
  assign bus.o_clear   = clear_q;
  assign bus.o_pending = pending;
  assign bus.o_overrun = overrun;

endmodule
